// File: rtl/tune_scheduler.sv
// Song sequencer and sound-effect arbiter for the square-wave tone generator.
// Optional build macro TUNE_SCHED_TEMPO_EN adds a tempo[1:0] input that shortens step and gap lengths.
module tune_scheduler #(
    parameter int          ADDR_W     = 8,
    parameter int          TICK_DIV   = 5,
    parameter int          STEP_TICKS = 4194304,
    parameter int          GAP_TICKS  = 262144,
    parameter logic [7:0]  END_CODE   = 8'hFF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              sfx_req,
    input  logic [5:0]        sfx_note,
    input  logic [7:0]        sfx_len,
    output logic              sfx_ack,
    output logic [5:0]        note,
    output logic              note_valid,
    output logic              busy,
    output logic              done
`ifdef TUNE_SCHED_TEMPO_EN
    ,
    input  logic [1:0]        tempo
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STEP_TICKS + 1);
    localparam logic [PW-1:0]     PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]     STEP_FULL = CW'(STEP_TICKS);
    localparam logic [CW-1:0]     GAP_FULL  = CW'(GAP_TICKS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_SFX} state_t;

    state_t            r_state, w_nx_state;
    logic [ADDR_W-1:0] r_rom_addr, w_nx_addr;
    logic [5:0]        r_note, w_nx_note;
    logic              r_note_valid, w_nx_nv;
    logic              r_sfx_ack, w_nx_ack;
    logic              r_done, w_nx_done;
    logic              r_busy, w_nx_busy;
    logic [PW-1:0]     r_pre, w_nx_pre;
    logic [CW-1:0]     r_step_cnt, w_nx_step;
    logic [7:0]        r_sfx_cnt, w_nx_sfx_cnt;
    logic [7:0]        r_sfx_len, w_nx_sfx_len;
    logic [ADDR_W-1:0] r_sv_addr, w_nx_sv_addr;
    logic [CW-1:0]     r_sv_step, w_nx_sv_step;
    logic [5:0]        r_sv_note, w_nx_sv_note;
    logic              r_sv_play, w_nx_sv_play;

    logic              w_tick;
    logic              w_end_song;
    logic              w_sfx_enter;
    logic [CW-1:0]     w_gap_use;
    logic [CW-1:0]     w_step_len, w_gap_len, w_gap_new;

`ifdef TUNE_SCHED_TEMPO_EN
    logic [CW-1:0] r_step_len, r_gap_len, w_step_new;

    assign w_step_new = STEP_FULL >> tempo;
    assign w_gap_new  = GAP_FULL >> tempo;
    assign w_step_len = r_step_len;
    assign w_gap_len  = r_gap_len;

    // Tempo is captured once per step, when the note is loaded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_step_len <= STEP_FULL;
            r_gap_len  <= GAP_FULL;
        end else if (r_state == S_WAIT && w_nx_state == S_PLAY) begin
            r_step_len <= w_step_new;
            r_gap_len  <= w_gap_new;
        end
    end
`else
    assign w_gap_new  = GAP_FULL;
    assign w_step_len = STEP_FULL;
    assign w_gap_len  = GAP_FULL;
`endif

    assign w_tick = (r_pre == PRE_LAST) &&
                    (((r_state == S_PLAY) && !pause) || (r_state == S_SFX));

    always_comb begin
        w_nx_state   = r_state;
        w_nx_addr    = r_rom_addr;
        w_nx_note    = r_note;
        w_nx_pre     = r_pre;
        w_nx_step    = r_step_cnt;
        w_nx_sfx_cnt = r_sfx_cnt;
        w_nx_sfx_len = r_sfx_len;
        w_nx_sv_addr = r_sv_addr;
        w_nx_sv_step = r_sv_step;
        w_nx_sv_note = r_sv_note;
        w_nx_sv_play = r_sv_play;
        w_nx_ack     = 1'b0;
        w_nx_done    = 1'b0;
        w_nx_nv      = 1'b0;
        w_nx_busy    = 1'b0;
        w_end_song   = 1'b0;
        w_sfx_enter  = 1'b0;
        w_gap_use    = w_gap_len;

        case (r_state)
            S_IDLE: begin
                if (sfx_req) begin
                    w_sfx_enter = 1'b1;
                end else if (start) begin
                    w_nx_state = S_FETCH;
                    w_nx_addr  = '0;
                end
            end
            S_FETCH: w_nx_state = S_WAIT;
            S_WAIT: begin
                if (rom_data == END_CODE) begin
                    w_end_song = 1'b1;
                end else begin
                    w_nx_state = S_PLAY;
                    w_nx_note  = rom_data[5:0];
                    w_nx_step  = '0;
                    w_nx_pre   = '0;
                    w_gap_use  = w_gap_new;
                end
            end
            S_PLAY: begin
                if (sfx_req) begin
                    w_sfx_enter = 1'b1;
                end else if (!pause) begin
                    w_nx_pre = w_tick ? '0 : r_pre + PW'(1);
                    if (w_tick) begin
                        if (r_step_cnt == w_step_len - CW'(1)) begin
                            if (r_rom_addr == ADDR_LAST) begin
                                w_end_song = 1'b1;
                            end else begin
                                w_nx_addr  = r_rom_addr + ADDR_W'(1);
                                w_nx_state = S_FETCH;
                            end
                        end else begin
                            w_nx_step = r_step_cnt + CW'(1);
                        end
                    end
                end
            end
            S_SFX: begin
                w_nx_pre = w_tick ? '0 : r_pre + PW'(1);
                if (w_tick) begin
                    if (r_sfx_cnt == r_sfx_len - 8'd1) begin
                        w_nx_state = r_sv_play ? S_PLAY : S_IDLE;
                        w_nx_addr  = r_sv_addr;
                        w_nx_step  = r_sv_step;
                        w_nx_note  = r_sv_note;
                        w_nx_pre   = '0;
                    end else begin
                        w_nx_sfx_cnt = r_sfx_cnt + 8'd1;
                    end
                end
            end
            default: w_nx_state = S_IDLE;
        endcase

        // End of song, whether from END_CODE or running off the top of the ROM.
        if (w_end_song) begin
            if (loop_en) begin
                w_nx_addr  = '0;
                w_nx_state = S_FETCH;
            end else begin
                w_nx_done  = 1'b1;
                w_nx_state = S_IDLE;
            end
        end

        if (w_sfx_enter) begin
            w_nx_state   = S_SFX;
            w_nx_ack     = 1'b1;
            w_nx_note    = sfx_note;
            w_nx_sfx_len = (sfx_len == 8'd0) ? 8'd1 : sfx_len;
            w_nx_sfx_cnt = 8'd0;
            w_nx_pre     = '0;
            w_nx_sv_addr = r_rom_addr;
            w_nx_sv_step = r_step_cnt;
            w_nx_sv_note = r_note;
            w_nx_sv_play = (r_state == S_PLAY);
        end

        if (stop) begin
            w_nx_state   = S_IDLE;
            w_nx_note    = r_note;
            w_nx_pre     = '0;
            w_nx_ack     = 1'b0;
            w_nx_done    = 1'b0;
            w_nx_sv_play = 1'b0;
        end

        // Gate is derived from the next state so it lines up with the registered note.
        case (w_nx_state)
            S_PLAY:  w_nx_nv = (w_nx_note != 6'd0) && (w_nx_step >= w_gap_use) && !pause;
            S_SFX:   w_nx_nv = 1'b1;
            default: w_nx_nv = 1'b0;
        endcase
        w_nx_busy = (w_nx_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_rom_addr   <= '0;
            r_note       <= '0;
            r_note_valid <= 1'b0;
            r_sfx_ack    <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_pre        <= '0;
            r_step_cnt   <= '0;
            r_sfx_cnt    <= '0;
            r_sfx_len    <= 8'd1;
            r_sv_addr    <= '0;
            r_sv_step    <= '0;
            r_sv_note    <= '0;
            r_sv_play    <= 1'b0;
        end else begin
            r_state      <= w_nx_state;
            r_rom_addr   <= w_nx_addr;
            r_note       <= w_nx_note;
            r_note_valid <= w_nx_nv;
            r_sfx_ack    <= w_nx_ack;
            r_done       <= w_nx_done;
            r_busy       <= w_nx_busy;
            r_pre        <= w_nx_pre;
            r_step_cnt   <= w_nx_step;
            r_sfx_cnt    <= w_nx_sfx_cnt;
            r_sfx_len    <= w_nx_sfx_len;
            r_sv_addr    <= w_nx_sv_addr;
            r_sv_step    <= w_nx_sv_step;
            r_sv_note    <= w_nx_sv_note;
            r_sv_play    <= w_nx_sv_play;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign note       = r_note;
    assign note_valid = r_note_valid;
    assign sfx_ack    = r_sfx_ack;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tune_scheduler.sv
// Directed self-checking bench for tune_scheduler with a 4-entry song {25,0,30,FF}.
module tb_tune_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = 8'hFF;
    logic       sfx_req = 1'b0;
    logic [5:0] sfx_note = 6'd0;
    logic [7:0] sfx_len = 8'd0;
    logic       sfx_ack;
    logic [5:0] note;
    logic       note_valid, busy, done;

    logic [7:0] rom [0:255];

    int n_checks = 0;
    int n_pass   = 0;

    tune_scheduler #(
        .ADDR_W(8), .TICK_DIV(2), .STEP_TICKS(8), .GAP_TICKS(2), .END_CODE(8'hFF)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .sfx_req(sfx_req), .sfx_note(sfx_note), .sfx_len(sfx_len), .sfx_ack(sfx_ack),
        .note(note), .note_valid(note_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        sfx_req = 1'b0; sfx_note = 6'd0; sfx_len = 8'd0;
        cyc(); cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_note(input logic [5:0] n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (note == n && busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(); cyc();
        n_checks++; if (rom_addr !== 8'd0) $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); else n_pass++;
        n_checks++; if (note !== 6'd0) $display("FAIL reset_note: got %0d want 0", note); else n_pass++;
        n_checks++; if (note_valid !== 1'b0) $display("FAIL reset_note_valid: got %b want 0", note_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (sfx_ack !== 1'b0) $display("FAIL reset_sfx_ack: got %b want 0", sfx_ack); else n_pass++;
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_basic_play();
        int g25 = 0, g30 = 0, g0 = 0, dcnt = 0, dcyc = -1, a3 = -1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (note_valid && note == 6'd25) g25++;
            if (note_valid && note == 6'd30) g30++;
            if (note_valid && note == 6'd0) g0++;
            if (rom_addr == 8'd3 && a3 < 0) a3 = i;
            if (done) begin dcnt++; dcyc = i; end
            if (dcnt > 0 && i > dcyc + 3) break;
        end
        n_checks++; if (g25 !== 12) $display("FAIL basic_gate25_clks: got %0d want 12", g25); else n_pass++;
        n_checks++; if (g0 !== 0) $display("FAIL basic_gate0_clks: got %0d want 0", g0); else n_pass++;
        n_checks++; if (g30 !== 12) $display("FAIL basic_gate30_clks: got %0d want 12", g30); else n_pass++;
        n_checks++; if (dcnt !== 1) $display("FAIL basic_done_count: got %0d want 1", dcnt); else n_pass++;
        n_checks++; if (dcyc - a3 !== 2) $display("FAIL basic_done_latency: got %0d want 2", dcyc - a3); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_loop();
        bit seen3 = 0, wrap = 0, replay = 0;
        int dcnt = 0;
        do_reset();
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (done) dcnt++;
            if (rom_addr == 8'd3) seen3 = 1'b1;
            if (seen3 && rom_addr == 8'd0) wrap = 1'b1;
            if (wrap && note == 6'd25 && note_valid) begin replay = 1'b1; break; end
        end
        n_checks++; if (wrap !== 1'b1) $display("FAIL loop_addr_wrap: got %b want 1", wrap); else n_pass++;
        n_checks++; if (replay !== 1'b1) $display("FAIL loop_replay25: got %b want 1", replay); else n_pass++;
        n_checks++; if (dcnt !== 0) $display("FAIL loop_no_done: got %0d want 0", dcnt); else n_pass++;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        loop_en = 1'b0;
        n_checks++; if (note_valid !== 1'b0) $display("FAIL loop_stop_nv: got %b want 0", note_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL loop_stop_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_pause();
        bit ok;
        int bad_nv = 0, bad_addr = 0, cnt = 0;
        logic first_nv;
        do_reset();
        pulse_start();
        wait_note(6'd25, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL pause_reach25: got %b want 1", ok); else n_pass++;
        for (int i = 0; i < 8; i++) cyc();
        n_checks++; if (note_valid !== 1'b1) $display("FAIL pause_nv_step4: got %b want 1", note_valid); else n_pass++;
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (note_valid !== 1'b0) bad_nv++;
            if (rom_addr !== 8'd0) bad_addr++;
        end
        n_checks++; if (bad_nv !== 0) $display("FAIL pause_nv_low: got %0d gated clks want 0", bad_nv); else n_pass++;
        n_checks++; if (bad_addr !== 0) $display("FAIL pause_addr_frozen: got %0d moved clks want 0", bad_addr); else n_pass++;
        pause = 1'b0;
        cyc();
        cnt = 1;
        first_nv = note_valid;
        while (rom_addr != 8'd1 && cnt < 40) begin
            cyc();
            cnt++;
        end
        n_checks++; if (first_nv !== 1'b1) $display("FAIL pause_release_nv: got %b want 1", first_nv); else n_pass++;
        n_checks++; if (cnt !== 8) $display("FAIL pause_remaining_clks: got %0d want 8", cnt); else n_pass++;
    endtask

    task automatic test_sfx_preempt();
        bit ok;
        int cnt = 0;
        do_reset();
        pulse_start();
        wait_note(6'd30, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL sfx_reach30: got %b want 1", ok); else n_pass++;
        for (int i = 0; i < 10; i++) cyc();
        sfx_req = 1'b1; sfx_note = 6'd40; sfx_len = 8'd3;
        cyc();
        sfx_req = 1'b0;
        n_checks++; if (sfx_ack !== 1'b1) $display("FAIL sfx_ack_entry: got %b want 1", sfx_ack); else n_pass++;
        n_checks++; if (note !== 6'd40) $display("FAIL sfx_note_entry: got %0d want 40", note); else n_pass++;
        cnt = 1;
        cyc();
        n_checks++; if (sfx_ack !== 1'b0) $display("FAIL sfx_ack_pulse_width: got %b want 0", sfx_ack); else n_pass++;
        while (note == 6'd40 && note_valid && cnt < 20) begin
            cnt++;
            cyc();
        end
        n_checks++; if (cnt !== 6) $display("FAIL sfx_gate_clks: got %0d want 6", cnt); else n_pass++;
        n_checks++; if (note !== 6'd30) $display("FAIL sfx_resume_note: got %0d want 30", note); else n_pass++;
        n_checks++; if (rom_addr !== 8'd2) $display("FAIL sfx_resume_addr: got %0d want 2", rom_addr); else n_pass++;
        n_checks++; if (note_valid !== 1'b1) $display("FAIL sfx_resume_nv: got %b want 1", note_valid); else n_pass++;
        cnt = 0;
        while (rom_addr != 8'd3 && cnt < 40) begin
            cyc();
            cnt++;
        end
        n_checks++; if (cnt !== 6) $display("FAIL sfx_resume_step5_clks: got %0d want 6", cnt); else n_pass++;
    endtask

    task automatic test_races();
        bit ok;
        int cnt = 0, bad = 0;
        // Effect request and start together in IDLE.
        do_reset();
        sfx_req = 1'b1; start = 1'b1; sfx_note = 6'd12; sfx_len = 8'd0;
        cyc();
        sfx_req = 1'b0; start = 1'b0;
        n_checks++; if (sfx_ack !== 1'b1) $display("FAIL race_ack: got %b want 1", sfx_ack); else n_pass++;
        n_checks++; if (note !== 6'd12) $display("FAIL race_note: got %0d want 12", note); else n_pass++;
        cnt = 1;
        cyc();
        while (note_valid && cnt < 20) begin
            cnt++;
            cyc();
        end
        n_checks++; if (cnt !== 2) $display("FAIL race_len0_clks: got %0d want 2", cnt); else n_pass++;
        for (int i = 0; i < 5; i++) cyc();
        n_checks++; if (busy !== 1'b0) $display("FAIL race_start_dropped: got %b want 0", busy); else n_pass++;

        // Stop while an effect is sounding.
        do_reset();
        pulse_start();
        wait_note(6'd25, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL stop_sfx_reach25: got %b want 1", ok); else n_pass++;
        sfx_req = 1'b1; sfx_note = 6'd50; sfx_len = 8'd5;
        cyc();
        sfx_req = 1'b0;
        n_checks++; if (note !== 6'd50) $display("FAIL stop_sfx_note: got %0d want 50", note); else n_pass++;
        cyc(); cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL stop_sfx_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (note_valid !== 1'b0) $display("FAIL stop_sfx_nv: got %b want 0", note_valid); else n_pass++;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (busy || note_valid) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL stop_sfx_no_resume: got %0d active clks want 0", bad); else n_pass++;

        // Asynchronous reset between clock edges.
        do_reset();
        pulse_start();
        wait_note(6'd25, ok);
        for (int i = 0; i < 6; i++) cyc();
        n_checks++; if (note_valid !== 1'b1) $display("FAIL areset_pre_nv: got %b want 1", note_valid); else n_pass++;
        #3;
        resetn = 1'b0;
        #1;
        n_checks++; if (note_valid !== 1'b0) $display("FAIL areset_nv: got %b want 0", note_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (note !== 6'd0) $display("FAIL areset_note: got %0d want 0", note); else n_pass++;
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        rom[0] = 8'd25;
        rom[1] = 8'd0;
        rom[2] = 8'd30;
        rom[3] = 8'hFF;
        test_reset();
        test_basic_play();
        test_loop();
        test_pause();
        test_sfx_preempt();
        test_races();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
